// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Subtraction is a + ~b + 1, so the serial carry starts at one.
  localparam logic SUB_CARRY_INIT = 1'b1;

endpackage

// File: rtl/serial_subtractor_fa_cell.sv
// Gate-level full adder cell shared by the serial arithmetic blocks.
module fa_cell (
  output wire sum,
  output wire carryout,
  input  wire a,
  input  wire b,
  input  wire carryin
);

  wire p;
  wire g;
  wire t;

  xor x0 (p, a, b);
  xor x1 (sum, p, carryin);
  and a0 (g, a, b);
  and a1 (t, p, carryin);
  or  o0 (carryout, g, t);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b using one full-adder cell over WIDTH cycles, with
// valid/ready handshakes on the operand and result sides.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] diff_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             borrow_q;
  logic             overflow_q;
  logic             b_inv;
  logic             sum_w;
  logic             cout_w;
  logic             last_w;

  assign b_inv  = ~b_sh_q[0];
  assign last_w = (cnt_q == CW'(WIDTH - 1));

  fa_cell u_fa (
    .sum     (sum_w),
    .carryout(cout_w),
    .a       (a_sh_q[0]),
    .b       (b_inv),
    .carryin (carry_q)
  );

  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_diff_w1
      assign diff_d = sum_w;
    end else begin : g_diff_wn
      assign diff_d = {sum_w, diff_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= SUB_CARRY_INIT;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= SUB_CARRY_INIT;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          diff_q  <= diff_d;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= cout_w;
          cnt_q   <= cnt_q + CW'(1);
          if (last_w) begin
            overflow_q <= carry_q ^ cout_w;
            borrow_q   <= ~cout_w;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign diff        = diff_q;
  assign borrow      = borrow_q;
  assign overflow    = overflow_q;
  assign zero        = (diff_q == '0);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic model plus per-cycle handshake checks.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             start_ready;
  logic             res_valid;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a          (a),
    .b          (b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .diff       (diff),
    .borrow     (borrow),
    .overflow   (overflow),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int bo;
    int ov;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  logic busy = 1'b0;
  int   since = 0;

  function automatic exp_t model(int x, int y);
    exp_t r;
    int   sx;
    int   sy;
    int   sd;
    sx   = (x >= (1 << (WIDTH - 1))) ? x - (1 << WIDTH) : x;
    sy   = (y >= (1 << (WIDTH - 1))) ? y - (1 << WIDTH) : y;
    sd   = sx - sy;
    r.d  = (x - y) & MASK;
    r.bo = (x < y) ? 1 : 0;
    r.ov = (sd > (1 << (WIDTH - 1)) - 1 || sd < -(1 << (WIDTH - 1))) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endtask

  // Track accepted operations and handoffs as observed at the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      since <= 0;
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        busy <= 1'b0;
        void'(exp_q.pop_front());
      end
      if (start_valid && start_ready) begin
        busy  <= 1'b1;
        since <= 0;
        exp_q.push_back(model(int'(a), int'(b)));
      end else if (busy) begin
        since <= since + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("start_ready", int'(start_ready), int'(!busy));
      chk("res_valid", int'(res_valid), (busy && since >= WIDTH) ? 1 : 0);
      if (res_valid && exp_q.size() > 0) begin
        chk("diff", int'(diff), exp_q[0].d);
        chk("borrow", int'(borrow), exp_q[0].bo);
        chk("overflow", int'(overflow), exp_q[0].ov);
        chk("zero", int'(zero), (exp_q[0].d == 0) ? 1 : 0);
      end
    end
  end

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input int lit, input int ed, input int eb, input int eo,
                       input int ez, input int hold, input int pulse);
    int w;
    @(negedge clk);
    a = x;
    b = y;
    start_valid = 1'b1;
    w = 0;
    while (!start_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!start_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    start_valid = 1'b0;
    w = 0;
    while (!res_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!res_valid) chk("result_timeout", 0, 1);
    if (lit != 0) begin
      chk("lit_latency", w, WIDTH);
      chk("lit_diff", int'(diff), ed);
      chk("lit_borrow", int'(borrow), eb);
      chk("lit_overflow", int'(overflow), eo);
      chk("lit_zero", int'(zero), ez);
    end
    for (int i = 0; i < hold; i++) begin
      if (pulse != 0 && i == 1) begin
        a = ~x;
        b = x;
        start_valid = 1'b1;
      end
      if (i == 3) start_valid = 1'b0;
      @(negedge clk);
    end
    if (pulse != 0) begin
      chk("bp_diff_held", int'(diff), ed);
      chk("bp_valid_held", int'(res_valid), 1);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    if (pulse != 0) chk("ready_after_handoff", int'(start_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    #1;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_borrow", int'(borrow), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_zero", int'(zero), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1, 8'h02, 0, 0, 0, 0, 0);
    do_op(8'h03, 8'h05, 1, 8'hFE, 1, 0, 0, 0, 0);
    do_op(8'h80, 8'h01, 1, 8'h7F, 0, 1, 0, 0, 0);
    do_op(8'h7F, 8'hFF, 1, 8'h80, 1, 1, 0, 0, 0);
    do_op(8'h5A, 8'h5A, 1, 8'h00, 0, 0, 1, 0, 0);
    do_op(8'h00, 8'h80, 1, 8'h80, 1, 1, 0, 0, 0);

    do_op(8'h23, 8'h11, 1, 8'h12, 0, 0, 0, 5, 1);
    do_op(8'h40, 8'h41, 1, 8'hFF, 1, 0, 0, 0, 0);

    // Abort an operation partway through the shift phase.
    @(negedge clk);
    a = 8'hC3;
    b = 8'h3C;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_start_ready", int'(start_ready), 1);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_diff", int'(diff), 0);
    chk("mid_rst_borrow", int'(borrow), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_zero", int'(zero), 1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h10, 8'h01, 1, 8'h0F, 0, 0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      ra = WIDTH'($urandom_range(0, MASK));
      rb = WIDTH'($urandom_range(0, MASK));
      do_op(ra, rb, 0, 0, 0, 0, 0, int'($urandom_range(0, 3)), 0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
